// File: rtl/hc595_driver.sv
// Upstream driver for a daisy chain of 74HC595 shift registers: accepts a word
// over valid/ready, shifts it MSB first on ser/srclk, then pulses rclk.
module hc595_driver #(
  parameter int NCHIP   = 1,
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NCHIP-1:0]   data,
  input  logic                 valid,
  output logic                 ready,
  input  logic                 clr_req,
  input  logic                 out_en,
  output logic                 busy,
  output logic                 ser,
  output logic                 srclk,
  output logic                 rclk,
  output logic                 srclr_n,
  output logic                 oe_n
);

  localparam int W  = 8 * NCHIP;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(W);
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_LATCH_HI = 3'd4,
    S_LATCH_LO = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [BW-1:0]  bitcnt_q, bitcnt_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic           phase_end_s;

  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic ser_q, ser_d;
  logic srclk_q, srclk_d;
  logic rclk_q, rclk_d;
  logic srclr_n_q, srclr_n_d;
  logic oe_n_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    phase_end_s = (phase_q == PH_LAST);

    case (state_q)
      S_IDLE: begin
        // Requests are only honoured once ready is visible on the pin.
        if (ready_q && clr_req) begin
          state_d = S_CLEAR;
        end else if (ready_q && valid) begin
          state_d  = S_SHIFT_LO;
          shreg_d  = data;
          bitcnt_d = BIT_LAST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (phase_end_s) state_d = S_IDLE;
        else             state_d = S_CLEAR;
      end
      S_SHIFT_LO: begin
        if (phase_end_s) state_d = S_SHIFT_HI;
        else             state_d = S_SHIFT_LO;
      end
      S_SHIFT_HI: begin
        if (phase_end_s) begin
          shreg_d = shreg_q << 1;
          if (bitcnt_q == '0) begin
            state_d = S_LATCH_HI;
          end else begin
            bitcnt_d = bitcnt_q - BW'(1);
            state_d  = S_SHIFT_LO;
          end
        end else begin
          state_d = S_SHIFT_HI;
        end
      end
      S_LATCH_HI: begin
        if (phase_end_s) state_d = S_LATCH_LO;
        else             state_d = S_LATCH_HI;
      end
      S_LATCH_LO: begin
        if (phase_end_s) state_d = S_IDLE;
        else             state_d = S_LATCH_LO;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_q == S_IDLE || phase_end_s) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PW'(1);
    end

    // Pins are registered from the next state so they line up with state_q.
    ready_d   = (state_d == S_IDLE);
    busy_d    = (state_d != S_IDLE);
    srclk_d   = (state_d == S_SHIFT_HI);
    rclk_d    = (state_d == S_LATCH_HI);
    srclr_n_d = (state_d != S_CLEAR);
    if (state_d == S_SHIFT_LO) begin
      ser_d = shreg_d[W-1];
    end else begin
      ser_d = ser_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      ser_q     <= 1'b0;
      srclk_q   <= 1'b0;
      rclk_q    <= 1'b0;
      srclr_n_q <= 1'b0;
      oe_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      ser_q     <= ser_d;
      srclk_q   <= srclk_d;
      rclk_q    <= rclk_d;
      srclr_n_q <= srclr_n_d;
      oe_n_q    <= ~out_en;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign ser     = ser_q;
  assign srclk   = srclk_q;
  assign rclk    = rclk_q;
  assign srclr_n = srclr_n_q;
  assign oe_n    = oe_n_q;

endmodule

// File: tb/tb_hc595_driver.sv
// Self-checking bench: two driver instances (1 chip / div 2, 2 chips / div 1)
// each feeding a behavioural 595 chain model sampled on the falling clock edge.
module tb_hc595_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A: NCHIP=1, CLK_DIV=2
  logic [7:0] a_data = 8'h00;
  logic a_valid = 1'b0, a_clr_req = 1'b0, a_out_en = 1'b1;
  logic a_ready, a_busy, a_ser, a_srclk, a_rclk, a_srclr_n, a_oe_n;
  // instance B: NCHIP=2, CLK_DIV=1
  logic [15:0] b_data = 16'h0000;
  logic b_valid = 1'b0, b_clr_req = 1'b0, b_out_en = 1'b1;
  logic b_ready, b_busy, b_ser, b_srclk, b_rclk, b_srclr_n, b_oe_n;

  hc595_driver #(.NCHIP(1), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .data(a_data), .valid(a_valid), .ready(a_ready),
    .clr_req(a_clr_req), .out_en(a_out_en), .busy(a_busy), .ser(a_ser),
    .srclk(a_srclk), .rclk(a_rclk), .srclr_n(a_srclr_n), .oe_n(a_oe_n));

  hc595_driver #(.NCHIP(2), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .data(b_data), .valid(b_valid), .ready(b_ready),
    .clr_req(b_clr_req), .out_en(b_out_en), .busy(b_busy), .ser(b_ser),
    .srclk(b_srclk), .rclk(b_rclk), .srclr_n(b_srclr_n), .oe_n(b_oe_n));

  localparam int LAT_A = (16 * 1 + 2) * 2;
  localparam int LAT_B = (16 * 2 + 2) * 1;

  int tests = 0;
  int fails = 0;

  // behavioural 595 chain models (clear wipes shift and storage registers)
  logic [7:0]  a_sr = 8'h00, a_q = 8'h00;
  logic [15:0] b_sr = 16'h0000, b_q = 16'h0000;
  logic a_psrclk = 1'b0, a_prclk = 1'b0, a_pser = 1'b0;
  logic b_psrclk = 1'b0, b_prclk = 1'b0, b_pser = 1'b0;
  int a_rises = 0, a_rpulses = 0, a_viol = 0;
  int b_rises = 0, b_rpulses = 0, b_viol = 0;
  bit a_serq[$];

  always @(negedge clk) begin
    if (a_srclr_n === 1'b0) begin
      a_sr <= 8'h00;
      a_q  <= 8'h00;
    end else begin
      if (a_srclk && !a_psrclk) begin
        a_sr    <= {a_sr[6:0], a_ser};
        a_rises <= a_rises + 1;
        a_serq.push_back(a_ser);
      end
      if (a_rclk && !a_prclk) begin
        a_q       <= a_sr;
        a_rpulses <= a_rpulses + 1;
      end
    end
    if ((a_srclk && a_rclk) || (a_ser !== a_pser && a_srclk === 1'b1)) a_viol <= a_viol + 1;
    a_psrclk <= a_srclk;
    a_prclk  <= a_rclk;
    a_pser   <= a_ser;
  end

  always @(negedge clk) begin
    if (b_srclr_n === 1'b0) begin
      b_sr <= 16'h0000;
      b_q  <= 16'h0000;
    end else begin
      if (b_srclk && !b_psrclk) begin
        b_sr    <= {b_sr[14:0], b_ser};
        b_rises <= b_rises + 1;
      end
      if (b_rclk && !b_prclk) begin
        b_q       <= b_sr;
        b_rpulses <= b_rpulses + 1;
      end
    end
    if ((b_srclk && b_rclk) || (b_ser !== b_pser && b_srclk === 1'b1)) b_viol <= b_viol + 1;
    b_psrclk <= b_srclk;
    b_prclk  <= b_rclk;
    b_pser   <= b_ser;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until ready; optionally pokes valid/data mid-frame on A.
  task automatic wait_ready(input bit use_b, input bit inject, output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      lat++;
      if (inject && lat == 10) begin a_valid = 1'b1; a_data = 8'h3C; end
      if (inject && lat == 12) a_valid = 1'b0;
      if (use_b ? b_ready : a_ready) break;
    end
  endtask

  task automatic frame_a(input logic [7:0] d, input bit inject, input string tag);
    int lat, base_r, base_p, base_q;
    logic [7:0] seq;
    base_r = a_rises; base_p = a_rpulses; base_q = a_serq.size();
    a_data = d; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    a_data = ~d;
    wait_ready(1'b0, inject, lat);
    seq = 8'h00;
    for (int i = 0; i < 8; i++) seq = {seq[6:0], a_serq[base_q + i]};
    check({tag, "_lat"}, lat, LAT_A);
    check({tag, "_rises"}, a_rises - base_r, 8);
    check({tag, "_rclk"}, a_rpulses - base_p, 1);
    check({tag, "_ser"}, seq, d);
    check({tag, "_q"}, a_q, d);
  endtask

  initial begin
    int lat, base_r, base_p, lowcnt;
    logic [7:0] d1, d2;
    logic [15:0] bd;
    logic exp_oe;

    // reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_srclr_n", a_srclr_n, 0);
      check("rst_oe_n", a_oe_n, 1);
      check("rst_clks", {a_srclk, a_rclk}, 0);
      check("rst_ready", a_ready, 0);
    end
    rst = 1'b0;
    tick();
    check("rel_ready", a_ready, 1);
    check("rel_srclr_n", a_srclr_n, 1);
    check("rel_oe_n", a_oe_n, 0);
    check("rel_ready_b", b_ready, 1);

    // single frame, with a mid-frame valid that must be ignored
    frame_a(8'hA5, 1'b1, "a5");
    check("a5_viol", a_viol, 0);

    // random frames
    for (int n = 0; n < 4; n++) frame_a(8'($urandom), 1'b0, "rnd");

    // back-to-back with valid held high; data changed after acceptance
    d1 = 8'($urandom); d2 = ~d1;
    a_data = d1; a_valid = 1'b1;
    tick();
    a_data = d2;
    wait_ready(1'b0, 1'b0, lat);
    check("b2b_lat1", lat, LAT_A);
    check("b2b_q1", a_q, d1);
    tick();
    check("b2b_restart", a_ready, 0);
    a_valid = 1'b0;
    wait_ready(1'b0, 1'b0, lat);
    check("b2b_lat2", lat, LAT_A);
    check("b2b_q2", a_q, d2);

    // clear has priority over valid
    frame_a(8'hFF, 1'b0, "ff");
    base_r = a_rises;
    a_clr_req = 1'b1; a_valid = 1'b1; a_data = 8'($urandom);
    tick();
    a_clr_req = 1'b0; a_valid = 1'b0;
    lowcnt = 0;
    while (a_srclr_n === 1'b0 && lowcnt < 10) begin lowcnt++; tick(); end
    check("clr_len", lowcnt, 2);
    check("clr_noshift", a_rises - base_r, 0);
    check("clr_ready", a_ready, 1);
    tick();
    check("clr_q", a_q, 8'h00);

    // reset in the middle of a frame
    frame_a(8'h5A, 1'b0, "pre");
    base_r = a_rises; base_p = a_rpulses;
    a_data = 8'hC3; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 100 && (a_rises - base_r) < 3; i++) tick();
    check("mid_rises", a_rises - base_r, 3);
    rst = 1'b1;
    tick();
    check("mid_srclr_n", a_srclr_n, 0);
    check("mid_srclk", a_srclk, 0);
    tick();
    check("mid_q", a_q, 8'h00);
    rst = 1'b0;
    tick();
    check("mid_ready", a_ready, 1);
    check("mid_no_rclk", a_rpulses - base_p, 0);

    // oe_n follows out_en one cycle later, also during a frame
    d1 = 8'($urandom);
    a_data = d1; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a_out_en = 1'($urandom_range(0, 1));
      exp_oe = !a_out_en;
      tick();
      check("oe_n", a_oe_n, exp_oe);
    end
    a_out_en = 1'b1;
    wait_ready(1'b0, 1'b0, lat);
    check("oe_frame_q", a_q, d1);
    check("a_viol", a_viol, 0);

    // two-chip chain at CLK_DIV=1
    for (int n = 0; n < 2; n++) begin
      bd = (n == 0) ? 16'h12F0 : 16'($urandom);
      base_r = b_rises;
      b_data = bd; b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      wait_ready(1'b1, 1'b0, lat);
      check("chain_lat", lat, LAT_B);
      check("chain_rises", b_rises - base_r, 16);
      check("chain_chip1", b_q[15:8], bd[15:8]);
      check("chain_chip0", b_q[7:0], bd[7:0]);
    end
    check("b_viol", b_viol, 0);
    check("b_oe_n", b_oe_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
